i2s_xfer_ctrl: RTL
==================

# i2s_xfer_ctrl

Frame sequencer between the I2S clock generator and the sample FIFOs. It tracks slot boundaries from the generated WS and SCK trigger, loads transmit samples MSB-first with the standard one-bit I2S delay, and assembles received bits into words. Channel mode and channel length are honoured per frame, and underrun/overrun events are flagged. It sits in the I2S core next to the clock generator and is fed by the register/FIFO layer.

## Interface
- DATA_WIDTH, 32, sample bus width; must be ≥ 32.
- clk_i  in  1  core clock (same clock as the clock generator)
- rst_n_i  in  1  reset, asynchronous, active-low
- en_i  in  1  core enable; low forces IDLE
- pol_i  in  1  SCK idle level / WS polarity, same value as fed to the clock generator
- chm_i  in  2  channel mode, `I2S_CHM_*` encoding
- chl_i  in  2  channel length, `I2S_DAT_*` encoding; N = 8/16/24/32 bits
- sck_i  in  1  current SCK level from the clock generator
- sck_trg_i  in  1  pulse: SCK toggles at the next clock edge
- ws_i  in  1  WS from the clock generator
- sdi_i  in  1  serial data in
- sdo_o  out  1  serial data out, registered
- tx_valid_i / tx_ready_o  in/out  1  TX sample handshake
- tx_data_i  in  DATA_WIDTH  TX sample, right-justified in bits [N-1:0]
- rx_valid_o / rx_ready_i  out/in  1  RX word handshake
- rx_data_o  out  DATA_WIDTH  RX word, zero-extended from bits [N-1:0]
- tx_udf_o, rx_ovf_o  out  1  one-cycle event pulses

## Operation
- Events: drive = sck_trg_i && sck_i == ~pol_i (SCK returns to idle). sample = sck_trg_i && sck_i == pol_i (SCK leaves idle). slot_start = ws_i != ws_q, where ws_q is ws_i registered; slot_start only counts while en_i is high.
- Left slot: ws_i == ~pol_i. Right slot: ws_i == pol_i.
- States:
  - IDLE: entered on reset or when en_i is low, from any state, within one cycle. Goes to SYNC when en_i is high.
  - SYNC: waits for the first slot_start, then goes to ACTIVE. No transfers and no flags in SYNC.
  - ACTIVE: normal transfer state.
- Latching: chm_i and chl_i are latched at every slot_start that enters a left slot, and are also latched on the SYNC→ACTIVE transition. Changes at any other time take effect only at the next left-slot start.
- Slot enabled:
  - stereo: both slots.
  - left: left slot only.
  - right: right slot only.
  - none: no slot.
- TX, first drive after slot_start (a drive in the slot_start cycle itself belongs to the previous slot):
  - If the slot is enabled, assert tx_ready_o for exactly that cycle.
  - If tx_valid_i is high, load tx_data_i[N-1:0] into the shift register.
  - Otherwise load zero and pulse tx_udf_o.
  - Disabled slots load zero with no handshake and no flag.
- TX shifting: sdo_o = shift-register MSB on drive events. After N bits sdo_o = 0 until the next slot.
- RX: a bit counter counts sample events after slot_start. Sample #0 is the delay bit and is ignored. Samples 1..N shift sdi_i in, MSB first. On sample N of an enabled slot the word completes.
- RX handoff:
  - If rx_valid_o is low, or rx_ready_i is high in that cycle, the word is written to rx_data_o and rx_valid_o is set.
  - Otherwise the new word is dropped, rx_data_o is kept, and rx_ovf_o pulses.
- rx_valid_o clears on rx_valid_o && rx_ready_i unless a new word is written in the same cycle.
- Bits beyond N in a slot are ignored.

## Timing
- Reset and IDLE values: every output is 0; shift registers, counters and ws_q are cleared. rx_valid_o is cleared when en_i falls.
- sdo_o updates on the same clock edge that toggles SCK to idle. Its registered state change occurs in the cycle after the drive event.
- tx_ready_o is combinational from state and events: high only in the load cycle.
- rx_data_o and rx_valid_o are registered, one cycle after the sample-N cycle.
- The handshake follows AXI-style rules: rx_data_o is stable while rx_valid_o && !rx_ready_i.

## Structure
- Add to the shared `i2s_define.sv`:
  - state encoding `I2S_XFER_IDLE/SYNC/ACTIVE`
  - a helper for channel length → N
- Existing `I2S_CHM_*` and `I2S_DAT_*` are reused.
- Registers use the existing `dffr` primitive.
- One natural sub-module: `i2s_rx_hold`, the RX output register with valid/ready and overflow detection.

## Test plan
- Stereo, N=16, tx words 0x0000A5F0 then 0x00000F0F, tx_valid always high → sdo_o shows 1010010111110000 starting one SCK after the WS edge, then 0000111100001111; tx_udf_o never pulses.
- Loopback sdo_o→sdi_i, stereo, N=24, TX sample 0x00123456 → rx_data_o = 0x00123456 with rx_valid_o; with a 32-bit TX word 0xFF123456 the RX word is still 0x00123456.
- Left-only mode, N=8 → exactly one tx_ready_o per frame, in the left slot; sdo_o = 0 throughout the right slot.
- tx_valid_i low at a load point → tx_udf_o pulses once and the slot transmits all zeros; rx_ready_i held low across two RX words → rx_ovf_o pulses once and rx_data_o keeps the first word.
- chl_i changed from 16 to 32 mid right slot → the current frame stays 16-bit and the next left slot uses 32; en_i dropped mid-slot → all outputs 0 next cycle, and SYNC is re-entered.

Source files
------------

// File: rtl/i2s_xfer_ctrl_pkg.sv
// Shared encodings for the I2S transfer sequencer: FSM states, channel mode
// and channel length codes, plus small decode helpers.
package i2s_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    I2S_XFER_IDLE   = 2'd0,
    I2S_XFER_SYNC   = 2'd1,
    I2S_XFER_ACTIVE = 2'd2
  } i2s_xfer_state_e;

  localparam logic [1:0] I2S_CHM_STEREO = 2'd0;
  localparam logic [1:0] I2S_CHM_LEFT   = 2'd1;
  localparam logic [1:0] I2S_CHM_RIGHT  = 2'd2;
  localparam logic [1:0] I2S_CHM_NONE   = 2'd3;

  localparam logic [1:0] I2S_DAT_8  = 2'd0;
  localparam logic [1:0] I2S_DAT_16 = 2'd1;
  localparam logic [1:0] I2S_DAT_24 = 2'd2;
  localparam logic [1:0] I2S_DAT_32 = 2'd3;

  function automatic logic [5:0] chl_to_n(input logic [1:0] chl);
    logic [5:0] n;
    n = 6'd32;
    case (chl)
      I2S_DAT_8:  n = 6'd8;
      I2S_DAT_16: n = 6'd16;
      I2S_DAT_24: n = 6'd24;
      default:    n = 6'd32;
    endcase
    return n;
  endfunction

  function automatic logic slot_enabled(input logic [1:0] chm, input logic is_left);
    logic en;
    en = 1'b0;
    case (chm)
      I2S_CHM_STEREO: en = 1'b1;
      I2S_CHM_LEFT:   en = is_left;
      I2S_CHM_RIGHT:  en = ~is_left;
      default:        en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/i2s_xfer_ctrl_rx_hold.sv
// RX output register: presents completed words with valid/ready and drops
// a new word (flagging overflow) while an unaccepted word is still held.
module i2s_xfer_ctrl_rx_hold #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_valid_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_ovf_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_ovf_o   <= 1'b0;
    end else if (clr_i) begin
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_ovf_o   <= 1'b0;
    end else begin
      rx_ovf_o <= 1'b0;
      if (wr_i) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= wr_data_i;
          rx_valid_o <= 1'b1;
        end else begin
          rx_ovf_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2s_xfer_ctrl.sv
// I2S frame sequencer: slot tracking, MSB-first TX with one-bit delay, RX word assembly.
// state  | meaning
// IDLE   | disabled, everything cleared
// SYNC   | enabled, waiting for the first WS edge
// ACTIVE | transferring slots
module i2s_xfer_ctrl
  import i2s_xfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  pol_i,
  input  logic [1:0]            chm_i,
  input  logic [1:0]            chl_i,
  input  logic                  sck_i,
  input  logic                  sck_trg_i,
  input  logic                  ws_i,
  input  logic                  sdi_i,
  output logic                  sdo_o,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  tx_udf_o,
  output logic                  rx_ovf_o
);

  i2s_xfer_state_e state_q;
  logic ws_q, slot_en_q, tx_pend_q, tx_udf_q;
  logic [1:0] chm_q, chl_q;
  logic [5:0] rx_cnt_q;
  logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q;

  logic drive, sample, slot_start, new_left, active, latch_now;
  logic tx_load, rx_wr, hold_clr;
  logic [1:0] chm_eff;
  logic [5:0] n_cur;
  logic [DATA_WIDTH-1:0] n_mask, tx_word, tx_aligned, rx_next;

  assign drive      = sck_trg_i && (sck_i == ~pol_i);
  assign sample     = sck_trg_i && (sck_i == pol_i);
  assign slot_start = en_i && (ws_i != ws_q);
  assign new_left   = (ws_i == ~pol_i);
  assign active     = en_i && (state_q == I2S_XFER_ACTIVE);
  assign latch_now  = slot_start && ((state_q == I2S_XFER_SYNC) ||
                                     (state_q == I2S_XFER_ACTIVE && new_left));
  assign chm_eff    = latch_now ? chm_i : chm_q;

  // Length is taken from the latched copy so a mid-frame chl_i change waits for the next left slot.
  assign n_cur      = chl_to_n(chl_q);
  assign n_mask     = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - int'(n_cur));
  assign tx_word    = (slot_en_q && tx_valid_i) ? (tx_data_i & n_mask) : '0;
  assign tx_aligned = tx_word << (DATA_WIDTH - int'(n_cur));
  assign rx_next    = ((rx_sr_q << 1) | DATA_WIDTH'(sdi_i)) & n_mask;

  // A drive coinciding with slot_start still shifts out the previous slot's tail.
  assign tx_load    = active && drive && tx_pend_q && !slot_start;
  assign tx_ready_o = tx_load && slot_en_q;
  assign rx_wr      = active && sample && !slot_start && slot_en_q && (rx_cnt_q == n_cur);
  assign hold_clr   = !en_i || (state_q != I2S_XFER_ACTIVE);
  assign tx_udf_o   = tx_udf_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= I2S_XFER_IDLE;
      ws_q      <= 1'b0;
      chm_q     <= '0;
      chl_q     <= '0;
      slot_en_q <= 1'b0;
      tx_pend_q <= 1'b0;
      tx_udf_q  <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      sdo_o     <= 1'b0;
    end else if (!en_i) begin
      state_q   <= I2S_XFER_IDLE;
      ws_q      <= 1'b0;
      chm_q     <= '0;
      chl_q     <= '0;
      slot_en_q <= 1'b0;
      tx_pend_q <= 1'b0;
      tx_udf_q  <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      sdo_o     <= 1'b0;
    end else begin
      ws_q     <= ws_i;
      tx_udf_q <= 1'b0;
      unique case (state_q)
        I2S_XFER_IDLE: state_q <= I2S_XFER_SYNC;
        I2S_XFER_SYNC: if (slot_start) state_q <= I2S_XFER_ACTIVE;
        default: ;
      endcase
      if (latch_now) begin
        chm_q <= chm_i;
        chl_q <= chl_i;
      end
      if (slot_start && state_q != I2S_XFER_IDLE) begin
        slot_en_q <= slot_enabled(chm_eff, new_left);
        tx_pend_q <= 1'b1;
        rx_cnt_q  <= '0;
        rx_sr_q   <= '0;
      end
      if (active) begin
        if (tx_load) begin
          sdo_o     <= tx_aligned[DATA_WIDTH-1];
          tx_sr_q   <= tx_aligned << 1;
          tx_pend_q <= 1'b0;
          tx_udf_q  <= slot_en_q && !tx_valid_i;
        end else if (drive) begin
          sdo_o   <= tx_sr_q[DATA_WIDTH-1];
          tx_sr_q <= tx_sr_q << 1;
        end
        // Sample #0 is the I2S delay bit; samples 1..N carry data.
        if (sample && !slot_start) begin
          if (rx_cnt_q == 6'd0) begin
            rx_cnt_q <= 6'd1;
          end else if (rx_cnt_q <= n_cur) begin
            rx_sr_q  <= rx_next;
            rx_cnt_q <= rx_cnt_q + 6'd1;
          end
        end
      end
    end
  end

  i2s_xfer_ctrl_rx_hold #(.DATA_WIDTH(DATA_WIDTH)) u_rx_hold (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (hold_clr),
    .wr_i       (rx_wr),
    .wr_data_i  (rx_next),
    .rx_ready_i (rx_ready_i),
    .rx_valid_o (rx_valid_o),
    .rx_data_o  (rx_data_o),
    .rx_ovf_o   (rx_ovf_o)
  );

endmodule
